// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile -- 32 x 32-bit MIPS general-purpose register file.
//
// The write-back stage writes one register per cycle. The decode stage reads
// two operands (rs on port 1, rt on port 2). rdata1 is the word that the decode
// operand pass-through stage forwards to execute. A third read port serves the
// board display.
//
// The block also keeps a committed-write counter for performance statistics.
// It counts writes that actually land in the file, so writes to r0 are not
// counted.
//
// Optional feature, enabled by defining the macro REGFILE_BYPASS_EN:
//   When a write to rN is in flight this cycle, rdata1 and rdata2 return wdata
//   combinationally for reads of rN. dbg_data is never bypassed; it always
//   shows the stored contents.
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset; clears all registers and wr_count
//   we        write enable from the write-back stage
//   waddr     destination register index
//   wdata     write-back data
//   raddr1    read port 1 index (rs)
//   rdata1    read port 1 data (zero-cycle latency)
//   raddr2    read port 2 index (rt)
//   rdata2    read port 2 data (zero-cycle latency)
//   dbg_addr  debug/display read index
//   dbg_data  debug read data; always the stored value
//   wr_count  number of committed register writes since reset; wraps silently
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // A write commits only when it targets a real register; r0 is hardwired 0.
  logic wr_commit;
  assign wr_commit = we && (waddr != '0);

  // NOTE: the array is reset on purpose, because software expects every
  // register to read 0 after reset. That rules out a RAM macro, and for a
  // 32-entry file flops are the right choice anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      // NOTE: non-blocking assignment, so a same-cycle read sees the old
      // value until the edge has passed.
      mem[waddr] <= wdata;
    end
  end

  // Counts every committed write, including rewrites of an identical value.
  // Natural binary wrap; no overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (wr_commit) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  // Asynchronous reads. An index of 0 is forced to 0 explicitly, so r0 never
  // depends on the contents of mem[0].
  always_comb begin
    // NOTE: every output gets its default first, so no path can infer a latch.
    rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
    rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
    dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
`ifdef REGFILE_BYPASS_EN
    // wr_commit already excludes waddr==0, so r0 can never be forwarded.
    if (wr_commit && (raddr1 == waddr)) rdata1 = wdata;
    if (wr_commit && (raddr2 == waddr)) rdata2 = wdata;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile -- directed, self-checking bench for wb_regfile.
//
// Two instances are built. u_dut uses the default parameters. u_small uses
// CNT_W=4 so that counter wrap can be reached in a few writes. Both share the
// same inputs.
//
// Inputs are driven just after the falling edge. Outputs are sampled 1 time
// unit after the inputs settle, or 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [4:0]  dbg_addr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;
  logic [31:0] s_rdata1;
  logic [31:0] s_rdata2;
  logic [31:0] s_dbg_data;
  logic [3:0]  s_wr_count;

  int checks   = 0;
  int failures = 0;

  wb_regfile u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  wb_regfile #(.CNT_W(4)) u_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (s_rdata1),
    .rdata2   (s_rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (s_dbg_data),
    .wr_count (s_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One committed edge with the given write inputs; we drops afterwards.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      raddr1   = 5'(i);
      raddr2   = 5'(i);
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (rdata1 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata1[%0d] got=%h exp=%h", i, rdata1, 32'h0);
      end
      checks++;
      if (rdata2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rdata2[%0d] got=%h exp=%h", i, rdata2, 32'h0);
      end
      checks++;
      if (dbg_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_dbg[%0d] got=%h exp=%h", i, dbg_data, 32'h0);
      end
    end
    checks++;
    if (wr_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_wr_count got=%0d exp=0", wr_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic();
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h12345678);
    raddr1   = 5'd5;
    raddr2   = 5'd31;
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_rdata1 got=%h exp=%h", rdata1, 32'hDEADBEEF);
    end
    checks++;
    if (rdata2 !== 32'h12345678) begin
      failures++;
      $display("FAIL basic_rdata2 got=%h exp=%h", rdata2, 32'h12345678);
    end
    checks++;
    if (dbg_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_dbg got=%h exp=%h", dbg_data, 32'hDEADBEEF);
    end
    checks++;
    if (wr_count !== 32'd2) begin
      failures++;
      $display("FAIL basic_wr_count got=%0d exp=2", wr_count);
    end

    // All three ports on the same register at once.
    raddr1   = 5'd31;
    raddr2   = 5'd31;
    dbg_addr = 5'd31;
    #1;
    checks++;
    if ({rdata1, rdata2, dbg_data} !== {3{32'h12345678}}) begin
      failures++;
      $display("FAIL same_index_3port got=%h/%h/%h exp=%h",
               rdata1, rdata2, dbg_data, 32'h12345678);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reg0();
    do_write(5'd0, 32'hFFFFFFFF);
    raddr1   = 5'd0;
    raddr2   = 5'd0;
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL r0_rdata1 got=%h exp=%h", rdata1, 32'h0);
    end
    checks++;
    if ((rdata2 !== 32'h0) || (dbg_data !== 32'h0)) begin
      failures++;
      $display("FAIL r0_rdata2_dbg got=%h/%h exp=0", rdata2, dbg_data);
    end
    checks++;
    if (wr_count !== 32'd2) begin
      failures++;
      $display("FAIL r0_wr_count got=%0d exp=2", wr_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  // we=0 with a live address and data must change nothing.
  task automatic test_we_low();
    @(negedge clk);
    we    = 1'b0;
    waddr = 5'd3;
    wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    raddr1 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL we_low_data got=%h exp=%h", rdata1, 32'h0);
    end
    checks++;
    if (wr_count !== 32'd2) begin
      failures++;
      $display("FAIL we_low_wr_count got=%0d exp=2", wr_count);
    end

    // Rewriting an identical value still counts.
    do_write(5'd5, 32'hDEADBEEF);
    checks++;
    if (wr_count !== 32'd3) begin
      failures++;
      $display("FAIL same_value_wr_count got=%0d exp=3", wr_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hazard();
    logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'hA5A5A5A5;
`else
    exp_pre = 32'h00000001;
`endif
    do_write(5'd7, 32'h1);
    @(negedge clk);
    we       = 1'b1;
    waddr    = 5'd7;
    wdata    = 32'hA5A5A5A5;
    raddr1   = 5'd7;
    raddr2   = 5'd7;
    dbg_addr = 5'd7;
    #1;
    checks++;
    if (rdata1 !== exp_pre) begin
      failures++;
      $display("FAIL hazard_pre_rdata1 got=%h exp=%h", rdata1, exp_pre);
    end
    checks++;
    if (rdata2 !== exp_pre) begin
      failures++;
      $display("FAIL hazard_pre_rdata2 got=%h exp=%h", rdata2, exp_pre);
    end
    checks++;
    if (dbg_data !== 32'h1) begin
      failures++;
      $display("FAIL hazard_pre_dbg got=%h exp=%h", dbg_data, 32'h1);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL hazard_post_rdata1 got=%h exp=%h", rdata1, 32'hA5A5A5A5);
    end
    checks++;
    if (dbg_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL hazard_post_dbg got=%h exp=%h", dbg_data, 32'hA5A5A5A5);
    end

    // Even with a write to r1 in flight, a read of r0 must return 0.
    @(negedge clk);
    we     = 1'b1;
    waddr  = 5'd1;
    wdata  = 32'h77;
    raddr1 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL hazard_r0 got=%h exp=%h", rdata1, 32'h0);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    do_write(5'd9, 32'h55);
    raddr1 = 5'd9;
    #1;
    checks++;
    if (rdata1 !== 32'h55) begin
      failures++;
      $display("FAIL async_pre got=%h exp=%h", rdata1, 32'h55);
    end
    // Assert reset between edges, with a write pending on the next edge.
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'h99;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL async_rdata1 got=%h exp=%h", rdata1, 32'h0);
    end
    checks++;
    if (wr_count !== 32'd0) begin
      failures++;
      $display("FAIL async_wr_count got=%0d exp=0", wr_count);
    end
    // The write lands on an edge while reset is held, so it must be lost.
    @(posedge clk);
    #1;
    we = 1'b0;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL async_write_lost got=%h exp=%h", rdata1, 32'h0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    // The first write commits on the first rising edge after release.
    do_write(5'd9, 32'h66);
    checks++;
    if ((rdata1 !== 32'h66) || (wr_count !== 32'd1)) begin
      failures++;
      $display("FAIL post_release_write got=%h/%0d exp=%h/1", rdata1, wr_count, 32'h66);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      do_write(5'd1, 32'(i));
    end
    raddr1 = 5'd1;
    #1;
    checks++;
    if (s_wr_count !== 4'd1) begin
      failures++;
      $display("FAIL wrap_small_count got=%0d exp=1", s_wr_count);
    end
    checks++;
    if (wr_count !== 32'd17) begin
      failures++;
      $display("FAIL wrap_big_count got=%0d exp=17", wr_count);
    end
    checks++;
    if ((rdata1 !== 32'd17) || (s_rdata1 !== 32'd17)) begin
      failures++;
      $display("FAIL wrap_r1 got=%h/%h exp=%h", rdata1, s_rdata1, 32'd17);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr1   = '0;
    raddr2   = '0;
    dbg_addr = '0;

    test_reset();
    test_basic();
    test_reg0();
    test_we_low();
    test_hazard();
    test_async_reset();
    test_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
